// File: rtl/meas_ctrl_fsm.sv
// Measurement sequencer: key press -> meas_trigger, measurement wait, output_trigger, output wait.
// Define KEY_DEBOUNCE_EN to insert a key debouncer after the synchronizer.
module meas_ctrl_fsm #(
    parameter int unsigned MEAS_CYCLES     = 1800,
    parameter int unsigned OUT_CYCLES      = 1800,
    parameter int unsigned DEBOUNCE_CYCLES = 36000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       meas_start_key_n,
    output logic       meas_trigger,
    output logic       output_trigger,
    output logic [2:0] state
);

    // state     | meaning
    // IDLE      | waiting for a key press
    // MEAS_TRIG | one-cycle start pulse to the measurement block
    // MEAS_WAIT | measurement window, MEAS_CYCLES long
    // OUT_TRIG  | one-cycle start pulse to the output block
    // OUT_WAIT  | output window, OUT_CYCLES long
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MEAS_TRIG = 3'd1,
        MEAS_WAIT = 3'd2,
        OUT_TRIG  = 3'd3,
        OUT_WAIT  = 3'd4
    } state_t;

    localparam int unsigned MEAS_EFF = (MEAS_CYCLES == 0) ? 1 : MEAS_CYCLES;
    localparam int unsigned OUT_EFF  = (OUT_CYCLES == 0) ? 1 : OUT_CYCLES;
    localparam int unsigned DEB_EFF  = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
    localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'(MEAS_EFF - 1);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_EFF - 1);
    localparam longint unsigned  CNT_MAX   = (64'd1 << CNT_W) - 64'd1;

    if ((64'(MEAS_EFF) > CNT_MAX) || (64'(OUT_EFF) > CNT_MAX) || (64'(DEB_EFF) > CNT_MAX))
    begin : g_cnt_w_check
        $error("meas_ctrl_fsm: CNT_W too narrow for the cycle parameters");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_sync1, key_sync2;
    logic             key_level, key_level_q;
    logic [1:0]       arm_pipe;
    logic             armed;
    logic             press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sync1 <= 1'b1;
            key_sync2 <= 1'b1;
        end else begin
            key_sync1 <= meas_start_key_n;
            key_sync2 <= key_sync1;
        end
    end

    // Presses are accepted only once the synchronized key has been seen released
    // after reset, so a key held through reset cannot start a sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_pipe <= 2'b00;
            armed    <= 1'b0;
        end else begin
            arm_pipe <= {arm_pipe[0], 1'b1};
            if (arm_pipe[1] && key_sync2) begin
                armed <= 1'b1;
            end
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_EFF - 1);

    logic             deb_level;
    logic [CNT_W-1:0] deb_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
        end else if (key_sync2 != deb_level) begin
            if (deb_cnt == DEB_LAST) begin
                deb_level <= key_sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign key_level = deb_level;
`else
    assign key_level = key_sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_level_q <= 1'b1;
        end else begin
            key_level_q <= key_level;
        end
    end

    assign press = armed && key_level_q && !key_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (press) begin
                    state_d = MEAS_TRIG;
                end
            end
            MEAS_TRIG: begin
                state_d = MEAS_WAIT;
                cnt_d   = '0;
            end
            MEAS_WAIT: begin
                if (cnt_q == MEAS_LAST) begin
                    state_d = OUT_TRIG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT_TRIG: begin
                state_d = OUT_WAIT;
                cnt_d   = '0;
            end
            OUT_WAIT: begin
                if (cnt_q == OUT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign meas_trigger   = (state_q == MEAS_TRIG);
    assign output_trigger = (state_q == OUT_TRIG);
    assign state          = state_q;

endmodule

// File: tb/tb_meas_ctrl_fsm.sv
// Self-checking bench for meas_ctrl_fsm: directed scenarios plus random key bursts against
// a sample-history reference model of the press/sequence rules.
module tb_meas_ctrl_fsm;

    localparam int M = 4;
    localparam int O = 3;
    localparam int D = 8;
`ifdef KEY_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       key_n;
    logic       meas_trigger;
    logic       output_trigger;
    logic [2:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model
    int pos;
    bit seen_high;
    bit k_q[$];
    bit lvl_q[$];
    bit deb_lvl;
    int run;
    int exp_meas_cnt = 0;
    int exp_out_cnt  = 0;
    int dut_meas_cnt = 0;
    int dut_out_cnt  = 0;

    meas_ctrl_fsm #(
        .MEAS_CYCLES    (M),
        .OUT_CYCLES     (O),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (24)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .meas_start_key_n(key_n),
        .meas_trigger    (meas_trigger),
        .output_trigger  (output_trigger),
        .state           (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // pos 0 = idle, 1 = meas pulse, then M wait cycles, out pulse, O wait cycles
    function automatic int exp_state(input int p);
        if (p == 0) return 0;
        if (p == 1) return 1;
        if (p <= M + 1) return 2;
        if (p == M + 2) return 3;
        return 4;
    endfunction

    task automatic model_reset();
        pos       = 0;
        seen_high = 1'b0;
        k_q.delete();
        lvl_q.delete();
        lvl_q.push_back(1'b1);
        deb_lvl = 1'b1;
        run     = 0;
    endtask

    // One rising edge: key samples form k_q; detector level history forms lvl_q.
    task automatic model_edge(input logic kv, input logic r);
        bit press;
        int n;
        int l;
        bit lvl_new;
        if (r) begin
            model_reset();
            return;
        end
        n = k_q.size();
        if (n >= 3 && k_q[n-3] == 1'b1) seen_high = 1'b1;
        l = lvl_q.size();
        press = (l >= 2) && (lvl_q[l-1] == 1'b0) && (lvl_q[l-2] == 1'b1) && seen_high;
        if (pos == 0) begin
            if (press) pos = 1;
        end else if (pos == M + O + 2) begin
            pos = 0;
        end else begin
            pos = pos + 1;
        end
        if (pos == 1) exp_meas_cnt++;
        if (pos == M + 2) exp_out_cnt++;
        k_q.push_back(kv);
        n = k_q.size();
        if (DEB) begin
            lvl_new = (n >= 3) ? k_q[n-3] : 1'b1;
            if (lvl_new != deb_lvl) begin
                run++;
                if (run == D) begin
                    deb_lvl = lvl_new;
                    run     = 0;
                end
            end else begin
                run = 0;
            end
            lvl_q.push_back(deb_lvl);
        end else begin
            lvl_q.push_back((n >= 2) ? k_q[n-2] : 1'b1);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0] es;
        es = 3'(exp_state(pos));
        n_cmp++;
        assert (state === es) else begin
            n_fail++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
        end
        n_cmp++;
        assert (meas_trigger === (es == 3'd1)) else begin
            n_fail++;
            $error("FAIL %s meas_trigger: observed %b expected %b", tag, meas_trigger, es == 3'd1);
        end
        n_cmp++;
        assert (output_trigger === (es == 3'd3)) else begin
            n_fail++;
            $error("FAIL %s output_trigger: observed %b expected %b", tag, output_trigger, es == 3'd3);
        end
    endtask

    task automatic check_counts(input string tag);
        n_cmp++;
        assert (dut_meas_cnt === exp_meas_cnt) else begin
            n_fail++;
            $error("FAIL %s meas pulses: observed %0d expected %0d", tag, dut_meas_cnt, exp_meas_cnt);
        end
        n_cmp++;
        assert (dut_out_cnt === exp_out_cnt) else begin
            n_fail++;
            $error("FAIL %s out pulses: observed %0d expected %0d", tag, dut_out_cnt, exp_out_cnt);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(key_n, rst);
        #1;
        if (meas_trigger === 1'b1) dut_meas_cnt++;
        if (output_trigger === 1'b1) dut_out_cnt++;
        check_outputs(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic press(input int low, input int high, input string tag);
        key_n = 1'b0;
        steps(low, tag);
        key_n = 1'b1;
        steps(high, tag);
    endtask

    // Key goes low before an edge; measure edges until meas_trigger and then to output_trigger.
    task automatic latency_check(input int exp_lat, input int hold);
        int lat;
        int gap;
        lat   = 0;
        gap   = 0;
        key_n = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            step("seq");
            if (i == hold) key_n = 1'b1;
            if (lat == 0 && meas_trigger === 1'b1) begin
                lat = i;
            end else if (lat != 0 && output_trigger === 1'b1) begin
                gap = i - lat;
                break;
            end
        end
        key_n = 1'b1;
        n_cmp++;
        assert (lat === exp_lat) else begin
            n_fail++;
            $error("FAIL latency: observed %0d expected %0d", lat, exp_lat);
        end
        n_cmp++;
        assert (gap === M + 1) else begin
            n_fail++;
            $error("FAIL trig_gap: observed %0d expected %0d", gap, M + 1);
        end
    endtask

    initial begin
        int low_max;
        int press_low;
        low_max   = DEB ? D + 6 : 6;
        press_low = DEB ? D + 4 : 3;
        model_reset();
        rst   = 1'b1;
        key_n = 1'b1;
        #2;
        check_outputs("in_reset");
        steps(4, "reset");
        rst = 1'b0;
        steps(6, "post_reset");

        // basic sequence with latency and trigger spacing
        latency_check(DEB ? D + 3 : 3, DEB ? 20 : 3);
        steps(15, "seq_tail");
        check_counts("basic");

        // press during MEAS_WAIT is ignored; a later press restarts
        press(press_low, 2, "first");
        press(press_low, 20, "ignored");
        press(press_low, 20, "restart");
        check_counts("ignore");

        // long hold gives one sequence only
        press(50, 20, "hold");
        check_counts("hold");

`ifdef KEY_DEBOUNCE_EN
        press(5, 20, "glitch");
        check_counts("glitch");
`endif

        // asynchronous reset mid-sequence
        key_n = 1'b0;
        steps(press_low, "pre_reset");
        key_n = 1'b1;
        steps(3, "pre_reset");
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_reset");
        steps(2, "async_reset");
        rst = 1'b0;
        steps(20, "after_reset");
        check_counts("async_reset");

        // key held low through reset must not start a sequence
        key_n = 1'b0;
        rst   = 1'b1;
        steps(3, "held_reset");
        rst = 1'b0;
        steps(DEB ? 3 * D : 10, "held_release");
        key_n = 1'b1;
        steps(DEB ? 2 * D : 6, "held_release");
        check_counts("held_reset");

        for (int b = 0; b < 40; b++) begin
            press($urandom_range(1, low_max), $urandom_range(1, 16), "random");
        end
        steps(DEB ? D + 20 : 20, "drain");
        check_counts("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
